// File: rtl/lut_loader.sv
// Branch-target LUT loader: streams 2**A entries, writes each as high part then low byte, reads back and flags the first mismatch.
// Four cycles per entry (accept, WR_HI, WR_LO, CHECK); stalls in WAIT_ENT with Entry_ready high while Entry_valid is low.
module lut_loader #(
  parameter int W = 10,
  parameter int A = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic         i_entry_valid,
  input  logic [W-1:0] i_entry,
  output logic         o_entry_ready,
  output logic         o_write_en,
  output logic         o_load_hi,
  output logic [A-1:0] o_imm,
  output logic [7:0]   o_acc,
  input  logic [W-1:0] i_target,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err,
  output logic [A-1:0] o_err_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ENT,
    S_WR_HI,
    S_WR_LO,
    S_CHECK,
    S_FIN
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [A-1:0] r_idx;
  logic [W-1:0] r_hold;
  logic         r_err;
  logic [A-1:0] r_err_idx;
  logic         w_accept;
  logic         w_last;
  logic         w_mismatch;
  logic [7:0]   w_hi_byte;

  assign w_accept   = (r_state == S_WAIT_ENT) && i_entry_valid && !i_abort;
  assign w_last     = (r_idx == {A{1'b1}});
  assign w_mismatch = (i_target != r_hold);

  always_comb begin
    w_hi_byte = '0;
    w_hi_byte[W-9:0] = r_hold[W-1:8];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    o_entry_ready = 1'b0;
    o_write_en    = 1'b0;
    o_load_hi     = 1'b0;
    o_imm         = '0;
    o_acc         = '0;
    o_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_WAIT_ENT;
      end
      S_WAIT_ENT: begin
        o_entry_ready = 1'b1;
        if (i_entry_valid) w_next = S_WR_HI;
      end
      S_WR_HI: begin
        o_write_en = 1'b1;
        o_load_hi  = 1'b1;
        o_imm      = r_idx;
        o_acc      = w_hi_byte;
        w_next     = S_WR_LO;
      end
      S_WR_LO: begin
        o_write_en = 1'b1;
        o_imm      = r_idx;
        o_acc      = r_hold[7:0];
        w_next     = S_CHECK;
      end
      S_CHECK: begin
        o_imm  = r_idx;
        w_next = w_last ? S_FIN : S_WAIT_ENT;
      end
      S_FIN: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Abort overrides every transition; in IDLE it is a no-op so Start still wins there.
    if (i_abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx     <= '0;
      r_hold    <= '0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end else begin
      if ((r_state == S_IDLE) && i_start) begin
        r_idx     <= '0;
        r_err     <= 1'b0;
        r_err_idx <= '0;
      end
      if (w_accept) r_hold <= i_entry;
      if ((r_state == S_CHECK) && !i_abort) begin
        if (w_mismatch && !r_err) begin
          r_err     <= 1'b1;
          r_err_idx <= r_idx;
        end
        if (!w_last) r_idx <= r_idx + A'(1);
      end
    end
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_err     = r_err;
  assign o_err_idx = r_err_idx;

endmodule

// File: doc/lut_loader.md
Name: lut_loader

Overview:
- Write-side sequencer for the branch-target LUT.
- Accepts 2**A target entries over a valid/ready stream and drives the LUT's two-step write interface: high part first with Load_Hi=1, then low byte.
- After each entry it reads the slot back and compares. A mismatch raises a sticky error and records the index.
- Sits between the boot/config path and the LUT; replaces software loading of the table through the accumulator.

Parameters:
- W, 10, LUT entry / branch target width; legal range 9..16.
- A, 4, LUT address width; the table has 2**A entries.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Start  in  1  one-cycle pulse; begins a full table load from index 0.
- Abort  in  1  synchronous abort of a load in progress.
- Entry_valid  in  1  Entry_in holds a valid target.
- Entry_in  in  W  next table entry, in index order.
- Entry_ready  out  1  loader accepts Entry_in this cycle.
- Write_En  out  1  LUT write enable.
- Load_Hi  out  1  1 = write high part, 0 = write low byte.
- Imm_out  out  A  LUT index (write address and read address).
- Acc_out  out  8  LUT write data.
- Target_in  in  W  LUT read data; combinational from Imm_out.
- Busy  out  1  load in progress.
- Done  out  1  one-cycle pulse when the last entry has been checked.
- Err  out  1  sticky readback mismatch flag.
- Err_idx  out  A  index of the first mismatch.

Behaviour:
- Reset (async, Reset=0): state IDLE. All outputs 0: Entry_ready, Write_En, Load_Hi, Imm_out, Acc_out, Busy, Done, Err, Err_idx. The index counter and entry hold register are also cleared. Write_En drops immediately, without waiting for a clock edge.
- States: IDLE, WAIT_ENT, WR_HI, WR_LO, CHECK, FIN.
- IDLE:
  - Start=1 -> WAIT_ENT; index=0, Err=0, Err_idx=0.
  - Start is ignored in every other state.
- WAIT_ENT:
  - Entry_ready=1.
  - On Entry_valid & Entry_ready: latch Entry_in into the hold register -> WR_HI.
  - Entry_ready is 0 in all other states.
- WR_HI: Write_En=1, Load_Hi=1, Imm_out=index, Acc_out = zero-extended hold[W-1:8] -> WR_LO.
- WR_LO: Write_En=1, Load_Hi=0, Imm_out=index, Acc_out=hold[7:0] -> CHECK.
- CHECK:
  - Write_En=0, Imm_out=index.
  - If Target_in != hold and Err=0: set Err=1 and Err_idx=index. Later mismatches do not overwrite Err_idx.
  - If index == 2**A-1 -> FIN; else index+1 -> WAIT_ENT.
- FIN: Done=1 for exactly one cycle -> IDLE.
- Busy=1 in every state except IDLE.
- Throughput: 4 cycles per entry when Entry_valid is held high. The accept cycle is followed by WR_HI, WR_LO and CHECK.
- Load_Hi is 0 and Acc_out is 0 whenever Write_En=0.
- Index counter is A bits wide. The FIN decision is made on index == 2**A-1, so the counter never wraps inside a load.
- Abort=1 in any non-IDLE state:
  - Next state IDLE, Write_En=0 from the next cycle, no Done pulse.
  - Err and Err_idx keep their values.
  - LUT contents are partial; a new Start is required.
  - Abort takes priority over every other transition. Abort in IDLE has no effect.
- Start and Abort asserted together in IDLE: Start wins.
- Entry_valid low in WAIT_ENT: stall indefinitely, with no LUT writes.
- Entry_valid outside WAIT_ENT: ignored; no data is consumed.
- Err persists until the next accepted Start or Reset.

Test Plan:
- Nominal load: Reset low 2 cycles, then Start. Stream entries i -> 10'h3A5 ^ i, Entry_valid held high. Required: 16 WR_HI/WR_LO pairs, 4 cycles per entry. Pair for index 5 drives Acc_out 2'b11 zero-extended (8'h03) then 8'hA0. Done pulses once, 64 cycles after the first accept. Err=0.
- Backpressure: drop Entry_valid for 7 cycles before index 9. Required: Entry_ready stays 1, Write_En stays 0 throughout the stall. Load resumes with index 9 and completes with correct data.
- Readback mismatch: the bench LUT model corrupts slots 3 and 11. Required: Err=1 from the CHECK cycle of index 3, Err_idx=3 (not 11), and Done still pulses.
- Abort mid-entry: assert Abort during WR_HI of index 6. Required: next cycle Write_En=0, Busy=0, no Done pulse. A following Start reloads from index 0 and clears Err.
- Async reset mid-load: pull Reset low between clock edges during WR_LO. Required: Write_En, Busy and Entry_ready all go 0 before the next clock edge. After Reset release the block is IDLE; Start with Abort asserted in the same cycle begins a load.
